// File: rtl/dut_port_arbiter.sv
// dut_port_arbiter
//   Two-client round-robin arbiter. It serialises single-bit read and write accesses
//   from two clients onto one dut-side write method and one read method. Only one
//   access is outstanding at a time.
//
//   Ports
//     CLK, RST                     clock, asynchronous active-high reset
//     cN_req/we/addr/wdata         client N request (held until cN_gnt)
//     cN_gnt                       pulse in the first ISSUE cycle of client N's access
//     cN_rvalid/cN_rdata           read response pulse and its data
//     write_address/data/en, write_rdy    dut write method
//     read_address/en, read_data/rdy      dut read method
//     err                          sticky timeout flag
//
//   Optional feature (macro ARB_TIMEOUT_EN): an ISSUE phase that sees 15 cycles with
//   the needed rdy low is aborted and err is set. Without the macro ISSUE waits
//   forever and err is tied low.
module dut_port_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       c0_req,
  input  logic       c0_we,
  input  logic [2:0] c0_addr,
  input  logic       c0_wdata,
  output logic       c0_gnt,
  output logic       c0_rvalid,
  output logic       c0_rdata,
  input  logic       c1_req,
  input  logic       c1_we,
  input  logic [2:0] c1_addr,
  input  logic       c1_wdata,
  output logic       c1_gnt,
  output logic       c1_rvalid,
  output logic       c1_rdata,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e     r_state;
  logic       r_we;
  logic [2:0] r_addr;
  logic       r_wdata;
  logic       r_win;    // client owning the outstanding access
  logic       r_last;   // client granted most recently
  logic       r_gnt0, r_gnt1;
  logic       r_rv0, r_rv1;
  logic       r_rd0, r_rd1;

  logic       w_any_req;
  logic       w_pick;
  logic       w_win_we;
  logic [2:0] w_win_addr;
  logic       w_win_wdata;
  logic       w_in_issue;
  logic       w_rdy;
  logic       w_tmo_hit;

  // On a tie the client not granted last wins; a lone requester always wins.
  assign w_any_req   = c0_req | c1_req;
  assign w_pick      = (c0_req & c1_req) ? ~r_last : c1_req;
  assign w_win_we    = w_pick ? c1_we    : c0_we;
  assign w_win_addr  = w_pick ? c1_addr  : c0_addr;
  assign w_win_wdata = w_pick ? c1_wdata : c0_wdata;

  assign w_in_issue = (r_state == StIssue);
  assign w_rdy      = r_we ? write_rdy : read_rdy;

  // Enables follow rdy combinationally so the handshake completes in the same cycle.
  assign write_en = w_in_issue &  r_we & write_rdy;
  assign read_en  = w_in_issue & ~r_we & read_rdy;

  assign write_address = r_addr;
  assign write_data    = r_wdata;
  assign read_address  = r_addr;

  assign c0_gnt    = r_gnt0;
  assign c1_gnt    = r_gnt1;
  assign c0_rvalid = r_rv0;
  assign c1_rvalid = r_rv1;
  assign c0_rdata  = r_rd0;
  assign c1_rdata  = r_rd1;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;
  logic       r_err;

  // Abort on the 15th stalled ISSUE cycle of this access.
  assign w_tmo_hit = w_in_issue & ~w_rdy & (r_tmo_cnt == 4'd14);
  assign err       = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tmo_cnt <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      if (r_state != StIssue) begin
        r_tmo_cnt <= 4'd0;
      end else if (!w_rdy) begin
        r_tmo_cnt <= r_tmo_cnt + 4'd1;
      end
      if (w_tmo_hit) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_addr  <= 3'd0;
      r_wdata <= 1'b0;
      r_win   <= 1'b0;
      r_last  <= 1'b1;  // client 0 wins the first tie
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_rd0   <= 1'b0;
      r_rd1   <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_we    <= w_win_we;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_win   <= w_pick;
            r_last  <= w_pick;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_state <= StIssue;
          end
        end
        StIssue: begin
          if (r_we) begin
            if (write_rdy) begin
              r_state <= StIdle;
            end else if (w_tmo_hit) begin
              r_state <= StIdle;
            end
          end else if (read_rdy) begin
            if (r_win) begin
              r_rd1 <= read_data;
              r_rv1 <= 1'b1;
            end else begin
              r_rd0 <= read_data;
              r_rv0 <= 1'b1;
            end
            r_state <= StResp;
          end else if (w_tmo_hit) begin
            r_state <= StIdle;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_port_arbiter.sv
module tb_dut_port_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       c0_req = 1'b0, c0_we = 1'b0, c0_wdata = 1'b0;
  logic [2:0] c0_addr = 3'd0;
  logic       c1_req = 1'b0, c1_we = 1'b0, c1_wdata = 1'b0;
  logic [2:0] c1_addr = 3'd0;
  logic       c0_gnt, c0_rvalid, c0_rdata, c1_gnt, c1_rvalid, c1_rdata;
  logic [2:0] write_address, read_address;
  logic       write_data, write_en, read_en, err;
  logic       write_rdy = 1'b1, read_rdy = 1'b1, read_data = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [14:0] exp_vec[$];
  int          exp_cyc[$];
  string       exp_name[$];

  dut_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en), .read_data(read_data),
    .read_rdy(read_rdy),
    .err(err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event vector: {g0, g1, we, waddr, wdata, re, raddr, v0, d0, v1, d1}; data fields
  // are zeroed unless their qualifier is high.
  function automatic logic [14:0] ev(input logic g0, input logic g1, input logic we,
                                     input logic [2:0] wa, input logic wd, input logic re,
                                     input logic [2:0] ra, input logic v0, input logic d0,
                                     input logic v1, input logic d1);
    return {g0, g1, we, we ? wa : 3'd0, we & wd, re, re ? ra : 3'd0,
            v0, v0 & d0, v1, v1 & d1};
  endfunction

  task automatic push(input string name, input logic [14:0] v, input int c);
    exp_name.push_back(name);
    exp_vec.push_back(v);
    exp_cyc.push_back(c);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every cycle with visible activity pops one expected event.
  always @(negedge CLK) begin
    logic [14:0] obs;
    string       nm;
    int          ec;
    logic [14:0] ev_exp;
    if ((c0_gnt | c1_gnt | write_en | read_en | c0_rvalid | c1_rvalid) === 1'b1) begin
      obs = ev(c0_gnt, c1_gnt, write_en, write_address, write_data, read_en, read_address,
               c0_rvalid, c0_rdata, c1_rvalid, c1_rdata);
      checks++;
      if (exp_vec.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %b at cycle %0d expected no activity", obs, cyc);
      end else begin
        nm     = exp_name.pop_front();
        ev_exp = exp_vec.pop_front();
        ec     = exp_cyc.pop_front();
        if (obs !== ev_exp || cyc != ec) begin
          errors++;
          $display("FAIL %s: got %b at cycle %0d expected %b at cycle %0d",
                   nm, obs, cyc, ev_exp, ec);
        end
      end
    end
  end

  // Single-client access with rdy high; called with the FSM idle.
  task automatic access(input string name, input bit c, input logic we,
                        input logic [2:0] a, input logic d);
    int k;
    if (c) begin
      c1_we = we; c1_addr = a; c1_wdata = d; c1_req = 1'b1;
    end else begin
      c0_we = we; c0_addr = a; c0_wdata = d; c0_req = 1'b1;
    end
    read_data = d;
    k = cyc;
    if (we) begin
      push({name, "_wr"}, ev(!c, c, 1, a, d, 0, 0, 0, 0, 0, 0), k + 1);
    end else begin
      push({name, "_rd"}, ev(!c, c, 0, 0, 0, 1, a, 0, 0, 0, 0), k + 1);
      push({name, "_rv"}, ev(0, 0, 0, 0, 0, 0, 0, !c, d, c, d), k + 2);
    end
    step();
    c0_req = 1'b0;
    c1_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    int k;
    step();
    step();
    // Reset state
    check("rst_c0_gnt", c0_gnt, 0);
    check("rst_c1_gnt", c1_gnt, 0);
    check("rst_rvalid", {c0_rvalid, c1_rvalid}, 0);
    check("rst_en", {write_en, read_en}, 0);
    check("rst_addr", {write_address, read_address, write_data}, 0);
    check("rst_err", err, 0);
    RST = 1'b0;
    step();

    access("c0_write_a3", 1'b0, 1'b1, 3'd3, 1'b1);
    access("c1_read_a5", 1'b1, 1'b0, 3'd5, 1'b1);

    // Both clients held: grants alternate starting with c0
    c0_we = 1; c0_addr = 3'd1; c0_wdata = 0; c0_req = 1;
    c1_we = 1; c1_addr = 3'd6; c1_wdata = 1; c1_req = 1;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push("rr_c0", ev(1, 0, 1, 3'd1, 0, 0, 0, 0, 0, 0, 0), k + 1 + 2 * i);
      else            push("rr_c1", ev(0, 1, 1, 3'd6, 1, 0, 0, 0, 0, 0, 0), k + 1 + 2 * i);
    end
    repeat (7) step();
    c0_req = 0;
    c1_req = 0;
    step();
    step();

    access("c0_read_a2", 1'b0, 1'b0, 3'd2, 1'b0);

    // Write stall: write_rdy low for 5 ISSUE cycles
    write_rdy = 0;
    c0_we = 1; c0_addr = 3'd4; c0_wdata = 1; c0_req = 1;
    k = cyc;
    push("stall_gnt", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), k + 1);
    step();
    c0_req = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_waddr", write_address, 3'd4);
      check("stall_wen", write_en, 0);
      step();
    end
    write_rdy = 1;
    push("stall_wr", ev(0, 0, 1, 3'd4, 1, 0, 0, 0, 0, 0, 0), cyc);
    step();
    step();

    // Read with read_rdy held low
    read_rdy = 0;
    c1_we = 0; c1_addr = 3'd7; c1_req = 1;
    k = cyc;
    push("tmo_gnt", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), k + 1);
    step();
    c1_req = 0;
    repeat (20) step();
`ifdef ARB_TIMEOUT_EN
    check("tmo_err", err, 1);
    read_rdy = 1;
    read_data = 0;
    step();
    step();
    check("tmo_err_sticky", err, 1);
`else
    check("tmo_err", err, 0);
    read_rdy = 1;
    read_data = 0;
    push("tmo_late_rd", ev(0, 0, 0, 0, 0, 1, 3'd7, 0, 0, 0, 0), cyc);
    push("tmo_late_rv", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), cyc + 1);
    step();
    step();
    step();
`endif

    // Reset during the ISSUE cycle of a c0 read
    read_data = 1;
    c0_we = 0; c0_addr = 3'd2; c0_req = 1;
    step();
    RST = 1;
    c0_req = 0;
    #1;
    check("midrst_gnt", {c0_gnt, c1_gnt}, 0);
    check("midrst_en", {write_en, read_en}, 0);
    check("midrst_rv", {c0_rvalid, c1_rvalid, c0_rdata, c1_rdata}, 0);
    check("midrst_addr", {write_address, read_address, write_data, err}, 0);
    step();
    step();
    RST = 0;
    step();
    c0_we = 1; c0_addr = 3'd1; c0_wdata = 1; c0_req = 1;
    c1_we = 1; c1_addr = 3'd2; c1_wdata = 0; c1_req = 1;
    push("post_rst_tie_c0", ev(1, 0, 1, 3'd1, 1, 0, 0, 0, 0, 0, 0), cyc + 1);
    step();
    c0_req = 0;
    c1_req = 0;
    repeat (4) step();

    while (exp_vec.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no event expected %b at cycle %0d",
               exp_name.pop_front(), exp_vec.pop_front(), exp_cyc.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
